uart_rx_pkt_ctrl: RTL and testbench

//  Sequencer for the 16x-oversampling UART receiver. It generates the receiver's Tick and drives RxEn/NBits.
//  It edge-detects RxDone and assembles received bytes into fixed-length checksummed packets.
//  It hands finished packets to downstream logic over a valid/ready handshake.

---
 rtl/uart_rx_pkt_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkt_ctrl
//  Brief    : Oversample tick generator and packet sequencer for the UART
//             receiver; frames header/payload/checksum packets for downstream.
//  Revision : 1.0
// ============================================================================
module uart_rx_pkt_ctrl #(
    parameter int         TICK_DIV    = 326,
    parameter int         PAYLOAD_LEN = 4,
    parameter logic [7:0] HDR         = 8'hA5,
    parameter int         TIMEOUT_CYC = 2000000,
    parameter logic [7:0] DATA_BITS   = 8'd8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Enable,
    input  logic                     RxDone,
    input  logic [7:0]               RxData,
    output logic                     RxEn,
    output logic                     Tick,
    output logic [7:0]               NBits,
    output logic [8*PAYLOAD_LEN-1:0] Pkt_data,
    output logic                     Pkt_valid,
    input  logic                     Pkt_ready,
    output logic                     Csum_err,
    output logic                     Timeout_err,
    output logic                     Overrun_err,
    output logic [7:0]               Pkt_count
);

    localparam int c_TCNT_W = $clog2(TICK_DIV);
    localparam int c_IDX_W  = $clog2(PAYLOAD_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_TCNT_W-1:0] c_TICK_LAST = c_TCNT_W'(TICK_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(PAYLOAD_LEN);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_TCNT_W-1:0]      r_tick_cnt;
    logic                     r_rxd_s1;
    logic                     r_rxd_s2;
    logic                     r_rxd_s3;
    logic                     w_accept;
    logic [c_IDX_W-1:0]       r_idx;
    logic [7:0]               r_sum;
    logic [c_TO_W-1:0]        r_to_cnt;
    logic                     r_rx_en;
    logic [8*PAYLOAD_LEN-1:0] r_pkt_data;
    logic                     r_pkt_valid;
    logic                     r_csum_err;
    logic                     r_to_err;
    logic                     r_ovr_err;
    logic [7:0]               r_pkt_count;

    always_ff @(posedge Clk) begin
        if (Rst || r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
        end
    end

    // RxDone comes from the Tick domain, so synchronize before edge-detecting
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rxd_s1 <= 1'b0;
            r_rxd_s2 <= 1'b0;
            r_rxd_s3 <= 1'b0;
        end else begin
            r_rxd_s1 <= RxDone;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_s3 <= r_rxd_s2;
        end
    end

    assign w_accept = r_rxd_s2 & ~r_rxd_s3;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_rx_en     <= 1'b0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_csum_err  <= 1'b0;
            r_to_err    <= 1'b0;
            r_ovr_err   <= 1'b0;
            r_pkt_count <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_csum_err <= 1'b0;
            r_to_err   <= 1'b0;
            r_ovr_err  <= 1'b0;
            if (!Enable) begin
                r_state     <= ST_IDLE;
                r_rx_en     <= 1'b0;
                r_pkt_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_HUNT;
                        r_rx_en <= 1'b1;
                    end
                    ST_HUNT: begin
                        if (w_accept && RxData == HDR) begin
                            r_state  <= ST_COLLECT;
                            r_idx    <= '0;
                            r_sum    <= '0;
                            r_to_cnt <= '0;
                        end
                    end
                    ST_COLLECT: begin
                        // An accept takes priority over a coincident timeout
                        if (w_accept) begin
                            r_to_cnt <= '0;
                            if (r_idx == c_IDX_LAST) begin
                                if (RxData == r_sum) begin
                                    r_state     <= ST_DELIVER;
                                    r_pkt_valid <= 1'b1;
                                    r_pkt_count <= r_pkt_count + 8'd1;
                                end else begin
                                    r_state    <= ST_HUNT;
                                    r_csum_err <= 1'b1;
                                end
                            end else begin
                                for (int i = 0; i < PAYLOAD_LEN; i++) begin
                                    if (r_idx == c_IDX_W'(i)) begin
                                        r_pkt_data[8*i +: 8] <= RxData;
                                    end
                                end
                                r_sum <= r_sum + RxData;
                                r_idx <= r_idx + c_IDX_W'(1);
                            end
                        end else if (r_to_cnt == c_TO_LAST) begin
                            r_state  <= ST_HUNT;
                            r_to_err <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                    ST_DELIVER: begin
                        if (w_accept) begin
                            r_ovr_err <= 1'b1;
                        end
                        if (r_pkt_valid && Pkt_ready) begin
                            r_state     <= ST_HUNT;
                            r_pkt_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_rx_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Tick        = (r_tick_cnt == c_TICK_LAST);
    assign NBits       = DATA_BITS;
    assign RxEn        = r_rx_en;
    assign Pkt_data    = r_pkt_data;
    assign Pkt_valid   = r_pkt_valid;
    assign Csum_err    = r_csum_err;
    assign Timeout_err = r_to_err;
    assign Overrun_err = r_ovr_err;
    assign Pkt_count   = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_pkt_ctrl
//  Brief    : Directed self-checking bench for uart_rx_pkt_ctrl with a
//             packet scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_pkt_ctrl;

    localparam int c_P_LEN   = 4;
    localparam int c_TO_CYC  = 3000;
    localparam int c_TICKDIV = 326;

    typedef struct packed {
        logic [8*c_P_LEN-1:0] data;
        logic [7:0]           count;
    } exp_pkt_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 rx_done;
    logic [7:0]           rx_data;
    logic                 rx_en;
    logic                 tick;
    logic [7:0]           nbits;
    logic [8*c_P_LEN-1:0] pkt_data;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic                 csum_err;
    logic                 timeout_err;
    logic                 overrun_err;
    logic [7:0]           pkt_count;

    int       total  = 0;
    int       passed = 0;
    int       failed = 0;
    int       n_csum = 0;
    int       n_to   = 0;
    int       n_ovr  = 0;
    logic     prev_valid = 1'b0;
    exp_pkt_t sb[$];

    uart_rx_pkt_ctrl #(
        .TICK_DIV    (c_TICKDIV),
        .PAYLOAD_LEN (c_P_LEN),
        .HDR         (8'hA5),
        .TIMEOUT_CYC (c_TO_CYC),
        .DATA_BITS   (8'd8)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Enable      (enable),
        .RxDone      (rx_done),
        .RxData      (rx_data),
        .RxEn        (rx_en),
        .Tick        (tick),
        .NBits       (nbits),
        .Pkt_data    (pkt_data),
        .Pkt_valid   (pkt_valid),
        .Pkt_ready   (pkt_ready),
        .Csum_err    (csum_err),
        .Timeout_err (timeout_err),
        .Overrun_err (overrun_err),
        .Pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (csum_err === 1'b1)    n_csum <= n_csum + 1;
        if (timeout_err === 1'b1) n_to   <= n_to + 1;
        if (overrun_err === 1'b1) n_ovr  <= n_ovr + 1;
    end

    // Scoreboard: each rising Pkt_valid consumes one expected packet
    always @(negedge clk) begin
        if (pkt_valid === 1'b1 && prev_valid === 1'b0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pkt", 64'(sb.size()), 64'd1);
            end else begin
                exp_pkt_t e;
                e = sb.pop_front();
                check("sb_pkt_data", 64'(pkt_data), 64'(e.data));
                check("sb_pkt_count", 64'(pkt_count), 64'(e.count));
            end
        end
        prev_valid = pkt_valid;
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, cs);
        send_byte(8'hA5, 4);
        send_byte(b0, 4);
        send_byte(b1, 4);
        send_byte(b2, 4);
        send_byte(b3, 4);
        send_byte(cs, 4);
    endtask

    task automatic handshake(input string tag);
        check({tag, "_valid_before"}, 64'(pkt_valid), 64'd1);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        check({tag, "_valid_after"}, 64'(pkt_valid), 64'd0);
    endtask

    initial begin
        int n;
        int c0, t0, o0;
        logic stable;
        logic [8*c_P_LEN-1:0] held;

        rst       = 1'b1;
        enable    = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        pkt_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rxen", 64'(rx_en), 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_nbits", 64'(nbits), 64'd8);
        check("rst_valid", 64'(pkt_valid), 64'd0);
        check("rst_data", 64'(pkt_data), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        check("rst_errs", 64'({csum_err, timeout_err, overrun_err}), 64'd0);
        rst = 1'b0;

        // Tick period
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 400);
        check("tick_first_seen", 64'(tick), 64'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 400);
        check("tick_period", 64'(n), 64'(c_TICKDIV));
        check("idle_rxen", 64'(rx_en), 64'd0);

        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("hunt_rxen", 64'(rx_en), 64'd1);

        // Good packet, then hold off ready
        sb.push_back('{data: 32'h04030201, count: 8'd1});
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check("good_valid", 64'(pkt_valid), 64'd1);
        held   = pkt_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (pkt_data !== held || pkt_valid !== 1'b1) stable = 1'b0;
        end
        check("good_held_stable", 64'(stable), 64'd1);
        handshake("good");

        // Bad checksum, then a normal packet
        c0 = n_csum;
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
        check("csum_pulses", 64'(n_csum - c0), 64'd1);
        check("csum_no_valid", 64'(pkt_valid), 64'd0);
        sb.push_back('{data: 32'h40302010, count: 8'd2});
        send_pkt(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
        handshake("after_csum");

        // Inter-byte timeout
        t0 = n_to;
        c0 = n_csum;
        send_byte(8'hA5, 4);
        send_byte(8'h01, 4);
        repeat (c_TO_CYC + 20) @(negedge clk);
        check("timeout_pulses", 64'(n_to - t0), 64'd1);
        send_byte(8'h02, 4);
        repeat (4) @(negedge clk);
        check("timeout_trail_valid", 64'(pkt_valid), 64'd0);
        check("timeout_trail_csum", 64'(n_csum - c0), 64'd0);
        check("timeout_single", 64'(n_to - t0), 64'd1);

        // Leading junk, good packet, overrun during DELIVER
        o0 = n_ovr;
        send_byte(8'h11, 4);
        send_byte(8'h22, 4);
        sb.push_back('{data: 32'h08070605, count: 8'd3});
        send_pkt(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        check("hunt_valid", 64'(pkt_valid), 64'd1);
        send_byte(8'h55, 4);
        check("ovr_pulses", 64'(n_ovr - o0), 64'd1);
        check("ovr_data_kept", 64'(pkt_data), 64'h08070605);
        check("ovr_valid_kept", 64'(pkt_valid), 64'd1);
        handshake("ovr");

        // Abort mid-packet
        c0 = n_csum; t0 = n_to; o0 = n_ovr;
        send_byte(8'hA5, 4);
        send_byte(8'h01, 4);
        enable = 1'b0;
        @(negedge clk);
        check("abort_rxen", 64'(rx_en), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_no_errs", 64'((n_csum - c0) + (n_to - t0) + (n_ovr - o0)), 64'd0);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Long RxDone on header must still yield a single accept
        sb.push_back('{data: 32'h04030201, count: 8'd4});
        send_byte(8'hA5, 5 * c_TICKDIV);
        send_byte(8'h01, 4);
        send_byte(8'h02, 4);
        send_byte(8'h03, 4);
        send_byte(8'h04, 4);
        send_byte(8'h0A, 4);
        check("long_csum_none", 64'(n_csum - c0), 64'd0);
        handshake("long");
        check("long_count", 64'(pkt_count), 64'd4);

        // Mid-operation reset
        send_byte(8'hA5, 4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_count", 64'(pkt_count), 64'd0);
        check("midrst_rxen", 64'(rx_en), 64'd0);
        check("midrst_data", 64'(pkt_data), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
